// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, types and helpers for the banked RAM.
//   BANK_DEPTH / BANK_AW : geometry of one 512-word bank.
//   state_t              : controller states (CLEAR fills the array with zeros,
//                          RUN serves requests).
//   addr_w()             : word-address width for a given bank count.
package ram_pkg;

    localparam int BANK_DEPTH = 512;
    localparam int BANK_AW    = 9;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int addr_w(input int banks);
        return $clog2(banks * BANK_DEPTH);
    endfunction

endpackage

// File: rtl/SB_RAM512x8.sv
// SB_RAM512x8: 512 x 8 single-clock-domain block RAM lane with registered read.
// Behavioural description of the iCE40 512x8 RAM mode; infers one block RAM.
//   RDATA  out 8  read data, updated on RCLK when RCLKE & RE, else held
//   RADDR  in  9  read address
//   RCLK, RCLKE, RE   read clock, clock enable, read enable
//   WADDR  in  9  write address
//   WCLK, WCLKE, WE   write clock, clock enable, write enable
//   WDATA  in  8  write data
// A read and a write to the same address on the same edge return the old data.
module SB_RAM512x8 (
    output logic [7:0] RDATA,
    input  logic [8:0] RADDR,
    input  logic       RCLK,
    input  logic       RCLKE,
    input  logic       RE,
    input  logic [8:0] WADDR,
    input  logic       WCLK,
    input  logic       WCLKE,
    input  logic       WE,
    input  logic [7:0] WDATA
);

    logic [7:0] mem [512];

    always_ff @(posedge WCLK) begin
        if (WCLKE && WE) begin
            mem[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) begin
            RDATA <= mem[RADDR];
        end
    end

endmodule

// File: rtl/ram_bank.sv
// ram_bank: one 512 x DATA_W bank made of DATA_W/8 byte-wide RAM lanes.
//   clk    in  1          clock
//   re     in  1          read enable, common to all lanes
//   raddr  in  9          read offset, shared by all lanes
//   rdata  out DATA_W     registered read data (held when re=0)
//   we     in  1          bank write select
//   wbe    in  DATA_W/8   byte enables; lane i is written when we & wbe[i]
//   waddr  in  9          write offset, shared by all lanes
//   wdata  in  DATA_W     write data
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [BANK_AW-1:0]    raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [BANK_AW-1:0]    waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int NB = DATA_W / 8;

    logic [NB-1:0] lane_we;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            lane_we[i] = we & wbe[i];
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        SB_RAM512x8 u_lane (
            .RDATA (rdata[8*i +: 8]),
            .RADDR (raddr),
            .RCLK  (clk),
            .RCLKE (1'b1),
            .RE    (re),
            .WADDR (waddr),
            .WCLK  (clk),
            .WCLKE (1'b1),
            .WE    (lane_we[i]),
            .WDATA (wdata[8*i +: 8])
        );
    end

endmodule

// File: rtl/banked_ram.sv
// banked_ram: single-clock RAM of BANKS x 512 words of DATA_W bits with
// per-byte write enables, one-cycle reads and write-first forwarding.
//   CLK_c      in  1         clock
//   RESETn_c   in  1         asynchronous reset, active-low
//   READY_c    out 1         high when requests are accepted
//   RE_c       in  1         read request
//   RADDR_c    in  ADDR_W    read word address
//   RDATA_OUT  out DATA_W    read data, held until the next read completes
//   RVALID_c   out 1         one-cycle pulse: RDATA_OUT updated
//   RERR_c     out 1         with RVALID_c: read address was out of range
//   WE_c       in  1         write request
//   WADDR_c    in  ADDR_W    write word address
//   WBE_c      in  DATA_W/8  byte enables
//   WDATA_IN   in  DATA_W    write data
//   WERR_c     out 1         one-cycle pulse: write address out of range, dropped
//   fsm_state  out state_t   controller state, for observation
// Handshake: a request is taken on every rising edge where READY_c=1 and its
// RE_c/WE_c is high; there is no back-pressure, results appear one cycle later.
module banked_ram
    import ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BANKS          = 3,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDR_W         = addr_w(BANKS)
) (
    input  logic                 CLK_c,
    input  logic                 RESETn_c,
    output logic                 READY_c,
    input  logic                 RE_c,
    input  logic [ADDR_W-1:0]    RADDR_c,
    output logic [DATA_W-1:0]    RDATA_OUT,
    output logic                 RVALID_c,
    output logic                 RERR_c,
    input  logic                 WE_c,
    input  logic [ADDR_W-1:0]    WADDR_c,
    input  logic [DATA_W/8-1:0]  WBE_c,
    input  logic [DATA_W-1:0]    WDATA_IN,
    output logic                 WERR_c,
    output state_t               fsm_state
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = BANKS * BANK_DEPTH;
    // Bank-index width; at least one bit so BANKS=1 still elaborates.
    localparam int BIW   = (ADDR_W > BANK_AW) ? (ADDR_W - BANK_AW) : 1;

    localparam logic [ADDR_W:0]   DEPTH_V     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    // Controller
    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready_q;
    logic              clearing;

    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RESET_STATE;
        endcase
    end

    assign clearing  = (state == CLEAR);
    assign fsm_state = state;

    // Address decode
    logic           w_oor, r_oor;
    logic [BIW-1:0] w_bank, r_bank;
    logic           wr_go, rd_go, rd_bank_go, fwd_hit;

    assign w_oor  = ({1'b0, WADDR_c} >= DEPTH_V);
    assign r_oor  = ({1'b0, RADDR_c} >= DEPTH_V);
    assign w_bank = BIW'(WADDR_c >> BANK_AW);
    assign r_bank = BIW'(RADDR_c >> BANK_AW);

    // ready_q doubles as the accept gate, so nothing is taken while clearing.
    assign wr_go      = ready_q & WE_c & ~w_oor;
    assign rd_go      = ready_q & RE_c;
    assign rd_bank_go = rd_go & ~r_oor;
    assign fwd_hit    = rd_bank_go & wr_go & (WADDR_c == RADDR_c);

    // Shared bank write port: the clear sequence borrows it while clearing.
    logic [BANK_AW-1:0] bank_waddr;
    logic [NB-1:0]      bank_wbe;
    logic [DATA_W-1:0]  bank_wdata;
    logic [BIW-1:0]     bank_wsel;
    logic               bank_wen;

    always_comb begin
        if (clearing) begin
            bank_waddr = clr_addr[BANK_AW-1:0];
            bank_wbe   = '1;
            bank_wdata = '0;
            bank_wsel  = BIW'(clr_addr >> BANK_AW);
            bank_wen   = 1'b1;
        end else begin
            bank_waddr = WADDR_c[BANK_AW-1:0];
            bank_wbe   = WBE_c;
            bank_wdata = WDATA_IN;
            bank_wsel  = w_bank;
            bank_wen   = wr_go;
        end
    end

    // Banks
    logic [BANKS-1:0]  bank_we, bank_re;
    logic [DATA_W-1:0] bank_rdata [BANKS];

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign bank_we[b] = bank_wen & (bank_wsel == BIW'(b));
        assign bank_re[b] = rd_bank_go & (r_bank == BIW'(b));

        ram_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (CLK_c),
            .re    (bank_re[b]),
            .raddr (RADDR_c[BANK_AW-1:0]),
            .rdata (bank_rdata[b]),
            .we    (bank_we[b]),
            .wbe   (bank_wbe),
            .waddr (bank_waddr),
            .wdata (bank_wdata)
        );
    end

    // Read-side pipeline registers
    logic              rvalid_q, rerr_q, werr_q;
    logic [BIW-1:0]    rbank_q;
    logic              fwd_hit_q;
    logic [NB-1:0]     fwd_be_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rd_mux, rd_word;

    always_ff @(posedge CLK_c or negedge RESETn_c) begin
        if (!RESETn_c) begin
            state      <= RESET_STATE;
            clr_addr   <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
            werr_q     <= 1'b0;
            rbank_q    <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            state    <= state_next;
            ready_q  <= (state_next == RUN);
            if (clearing) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
            rvalid_q <= rd_go;
            rerr_q   <= rd_go & r_oor;
            werr_q   <= ready_q & WE_c & w_oor;
            if (rd_go) begin
                rbank_q    <= r_bank;
                fwd_hit_q  <= fwd_hit;
                fwd_be_q   <= WBE_c;
                fwd_data_q <= WDATA_IN;
            end
            // Capture the completed read so RDATA_OUT stays put afterwards.
            if (rvalid_q) begin
                hold_q <= rd_word;
            end
        end
    end

    // Output mux on the registered bank index, then overlay forwarded lanes.
    // The bank itself returns pre-write data on a same-edge hit.
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (rbank_q == BIW'(b)) begin
                rd_mux = bank_rdata[b];
            end
        end
        rd_word = rd_mux;
        for (int i = 0; i < NB; i++) begin
            if (fwd_hit_q && fwd_be_q[i]) begin
                rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
        if (rerr_q) begin
            rd_word = '0;
        end
    end

    assign READY_c   = ready_q;
    assign RVALID_c  = rvalid_q;
    assign RERR_c    = rerr_q;
    assign WERR_c    = werr_q;
    assign RDATA_OUT = rvalid_q ? rd_word : hold_q;

endmodule

// File: tb/tb_banked_ram.sv
module tb_banked_ram;
    import ram_pkg::*;

    localparam int DATA_W = 32;
    localparam int BANKS  = 3;
    localparam int NB     = DATA_W / 8;
    localparam int DEPTH  = BANKS * 512;
    localparam int ADDR_W = 11;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              ready, rvalid, rerr, werr;
    logic              re, we;
    logic [ADDR_W-1:0] raddr, waddr;
    logic [NB-1:0]     wbe;
    logic [DATA_W-1:0] wdata, rdata;
    state_t            fsm_state;

    banked_ram #(
        .DATA_W         (DATA_W),
        .BANKS          (BANKS),
        .CLEAR_ON_RESET (1)
    ) dut (
        .CLK_c     (clk),
        .RESETn_c  (rst_n),
        .READY_c   (ready),
        .RE_c      (re),
        .RADDR_c   (raddr),
        .RDATA_OUT (rdata),
        .RVALID_c  (rvalid),
        .RERR_c    (rerr),
        .WE_c      (we),
        .WADDR_c   (waddr),
        .WBE_c     (wbe),
        .WDATA_IN  (wdata),
        .WERR_c    (werr),
        .fsm_state (fsm_state)
    );

    typedef struct {
        logic              re;
        logic [ADDR_W-1:0] raddr;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [NB-1:0]     wbe;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_rvalid;
        logic              exp_rerr;
        logic              exp_werr;
    } vec_t;

    // Reference model: a flat word array, written before it is read so a
    // same-edge read sees the new lanes; out-of-range reads return zero.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_hold;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        re    = 1'b0;
        we    = 1'b0;
        raddr = '0;
        waddr = '0;
        wbe   = '0;
        wdata = '0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_hold = '0;
    endtask

    task automatic model_step(input vec_t v, output logic [DATA_W-1:0] e_rdata,
                              output logic e_rvalid, output logic e_rerr, output logic e_werr);
        int wa, ra;
        wa = int'(v.waddr);
        ra = int'(v.raddr);
        if (v.we && wa < DEPTH) begin
            for (int i = 0; i < NB; i++) begin
                if (v.wbe[i]) model_mem[wa][8*i +: 8] = v.wdata[8*i +: 8];
            end
        end
        if (v.re) exp_hold = (ra < DEPTH) ? model_mem[ra] : '0;
        e_rdata  = exp_hold;
        e_rvalid = v.re;
        e_rerr   = v.re && (ra >= DEPTH);
        e_werr   = v.we && (wa >= DEPTH);
    endtask

    // Driver: present one request, step one edge, settle.
    task automatic drive(input vec_t v);
        re    = v.re;
        raddr = v.raddr;
        we    = v.we;
        waddr = v.waddr;
        wbe   = v.wbe;
        wdata = v.wdata;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // use_table=1: compare against the record's constants; else against the model.
    task automatic run_cycle(input vec_t v, input bit use_table, input string tag);
        logic [DATA_W-1:0] m_rdata;
        logic              m_rvalid, m_rerr, m_werr;
        model_step(v, m_rdata, m_rvalid, m_rerr, m_werr);
        drive(v);
        if (use_table) begin
            m_rdata  = v.exp_rdata;
            m_rvalid = v.exp_rvalid;
            m_rerr   = v.exp_rerr;
            m_werr   = v.exp_werr;
        end
        check({tag, ".rdata"},  rdata,  m_rdata);
        check({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
        check({tag, ".rerr"},   32'(rerr),   32'(m_rerr));
        check({tag, ".werr"},   32'(werr),   32'(m_werr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"},  32'(ready),  32'd0);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
        check({tag, ".rerr"},   32'(rerr),   32'd0);
        check({tag, ".werr"},   32'(werr),   32'd0);
        check({tag, ".rdata"},  rdata,       32'd0);
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count edges after release until READY; optionally hammer RE/WE meanwhile.
    task automatic wait_ready(input bit poke, input int expect_edges, input string tag);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        while (n < 3000) begin
            if (poke) begin
                re    = 1'($urandom_range(0, 1));
                raddr = ADDR_W'($urandom_range(0, 2047));
                we    = 1'($urandom_range(0, 1));
                waddr = ADDR_W'($urandom_range(0, 2047));
                wbe   = '1;
                wdata = $urandom() | 32'h1;
            end
            @(posedge clk);
            n++;
            #1;
            if (rvalid || werr) bad = 1'b1;
            if (ready) break;
        end
        idle_inputs();
        check({tag, ".ready_edge"}, 32'(n), 32'(expect_edges));
        check({tag, ".quiet_in_clear"}, 32'(bad), 32'd0);
        model_zero();
    endtask

    function automatic vec_t mk(input logic r, input int ra, input logic w, input int wa,
                                input logic [NB-1:0] be, input logic [31:0] wd,
                                input logic [31:0] er, input logic ev, input logic ee,
                                input logic ew);
        vec_t v;
        v.re = r; v.raddr = ADDR_W'(ra); v.we = w; v.waddr = ADDR_W'(wa);
        v.wbe = be; v.wdata = wd; v.exp_rdata = er; v.exp_rvalid = ev;
        v.exp_rerr = ee; v.exp_werr = ew;
        return v;
    endfunction

    vec_t vecs [$];

    function automatic vec_t rand_vec();
        vec_t v;
        int   pick;
        v = mk(0, 0, 0, 0, '0, '0, '0, 0, 0, 0);
        v.re  = 1'($urandom_range(0, 1));
        v.we  = 1'($urandom_range(0, 1));
        pick  = int'($urandom_range(0, 9));
        v.raddr = (pick < 2) ? ADDR_W'($urandom_range(DEPTH, 2047))
                             : ADDR_W'($urandom_range(0, 2) * 512 + $urandom_range(0, 15));
        pick  = int'($urandom_range(0, 9));
        if (pick < 3)      v.waddr = v.raddr;
        else if (pick < 4) v.waddr = ADDR_W'($urandom_range(DEPTH, 2047));
        else               v.waddr = ADDR_W'($urandom_range(0, 2) * 512 + $urandom_range(0, 15));
        v.wbe   = NB'($urandom_range(0, 15));
        v.wdata = $urandom();
        return v;
    endfunction

    initial begin
        //                  re  raddr  we waddr  wbe     wdata          exp_rdata    rv re we
        vecs.push_back(mk(1, 'h000, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(1, 'h3FF, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(1, 'h5FF, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0,     1, 'h200, 4'hF, 32'hDEADBEEF, 32'h00000000, 0, 0, 0));
        vecs.push_back(mk(1, 'h200, 0, 0,     4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(1, 'h000, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0,     1, 'h010, 4'hF, 32'h11223344, 32'h00000000, 0, 0, 0));
        vecs.push_back(mk(1, 'h010, 1, 'h010, 4'h5, 32'hAABBCCDD, 32'h11BB33DD, 1, 0, 0));
        vecs.push_back(mk(1, 'h010, 0, 0,     4'h0, 32'h0,        32'h11BB33DD, 1, 0, 0));
        vecs.push_back(mk(1, 'h600, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 1, 0));
        vecs.push_back(mk(0, 0,     1, 'h7FF, 4'hF, 32'h12345678, 32'h00000000, 0, 0, 1));
        vecs.push_back(mk(1, 'h200, 0, 0,     4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(1, 'h5FF, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(1, 'h1FF, 0, 0,     4'h0, 32'h0,        32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0,     1, 'h200, 4'h0, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0));
        vecs.push_back(mk(1, 'h200, 1, 'h400, 4'hF, 32'hCAFEF00D, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(1, 'h400, 0, 0,     4'h0, 32'h0,        32'hCAFEF00D, 1, 0, 0));
        vecs.push_back(mk(1, 'h3FF, 1, 'h3FF, 4'hF, 32'h55AA55AA, 32'h55AA55AA, 1, 0, 0));
        vecs.push_back(mk(1, 'h7FF, 1, 'h005, 4'hF, 32'h01020304, 32'h00000000, 1, 1, 0));
        vecs.push_back(mk(1, 'h005, 0, 0,     4'h0, 32'h0,        32'h01020304, 1, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0,     4'h0, 32'h0,        32'h01020304, 0, 0, 0));

        idle_inputs();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("por");

        // First bring-up, then leave garbage behind.
        do_reset("rst1");
        wait_ready(1'b0, 1536, "clr1");
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v     = rand_vec();
            v.re  = 1'b0;
            v.we  = 1'b1;
            v.wbe = '1;
            v.waddr = ADDR_W'($urandom_range(0, DEPTH - 1));
            run_cycle(v, 1'b0, "garbage");
        end
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v = mk(0, 0, 1, (i * 512) + 511, 4'hF, 32'hBAD0BAD0, 0, 0, 0, 0);
            run_cycle(v, 1'b0, "garbage_edge");
        end

        // Re-clear with requests hammering the ports during CLEAR.
        do_reset("rst2");
        wait_ready(1'b1, 1536, "clr2");

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            run_cycle(rand_vec(), 1'b0, "rand");
        end

        // Reset in the middle of a read response.
        begin
            vec_t v;
            logic [DATA_W-1:0] m_rdata;
            logic m_rv, m_re, m_we;
            v = mk(1, 'h200, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
            model_step(v, m_rdata, m_rv, m_re, m_we);
            drive(v);
            check("midread.rvalid_before", 32'(rvalid), 32'd1);
            check("midread.rdata_before", rdata, m_rdata);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midread");
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end

        // Reset when the clear counter has reached address 700.
        repeat (700) @(posedge clk);
        #2;
        check("midclr.ready_low", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midclr");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(1'b0, 1536, "clr3");

        // Array must be zero everywhere after the restarted clear.
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            int a;
            a = (i < 6) ? ((i % 3) * 512 + ((i / 3) * 511)) : int'($urandom_range(0, DEPTH - 1));
            v = mk(1, a, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
            run_cycle(v, 1'b0, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
